cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Parametrised multi-cycle RV32I control sequencer: owns PC, instruction register, FETCH/EX/MEM/WB/TRAP state machine and both bus handshakes, driving the existing decoder, regfile, ALU and SDRAM controller. Next generation of the core control loop. Adds a configurable reset and trap vector, misaligned-access and jump-target traps, a bus watchdog, a 64-bit retired-instruction counter and an optional MEM-stage bypass.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- TRAP_VEC, 32'h0000_0100, PC loaded on any trap
- TIMEOUT_CYCLES, 1024, max cycles a bus request may stay unanswered (≥2)

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - clk  in  1  system clock
  - rst_n  in  1  synchronous, active-low reset
- Fetch inputs from decode and register file:
  - op  in  7  decoded opcode
  - func3  in  3  decoded funct3
  - imm  in  32  decoded immediate
  - alu_result  in  32  ALU output
  - rs2_data  in  32  regfile port 2
- Instruction bus:
  - ibus_en  out  1  fetch request
  - ibus_addr  out  32  fetch address
  - ibus_valid  in  1  fetch data valid
  - ibus_rdata  in  32  fetched word
- Data bus:
  - dbus_en  out  1  data request
  - dbus_rw  out  1  1 = store
  - dbus_addr  out  32  data address
  - dbus_wdata  out  32  store data
  - dbus_oplen  out  2  0 = byte, 1 = half, 2 = word
  - dbus_unsigned  out  1  zero-extend load
  - dbus_valid  in  1  data done
  - dbus_rdata  in  32  load result
- Outputs to the rest of the core:
  - instruction  out  32  instruction register, feeds the decoder
  - pc  out  32  current PC
  - rf_we  out  1  regfile write strobe
  - rf_wdata  out  32  regfile write data
  - instret  out  64  retired-instruction count
  - trap  out  1  one-cycle trap pulse
  - trap_cause  out  4  RISC-V mcause code of last trap
  - trap_pc  out  32  PC of the faulting instruction

## Operation
**Reset values.**
- Outputs: pc = RESET_PC, instruction = 32'h0000_0013 (NOP), trap_cause = 0, trap_pc = 0, instret = 0.
- All strobes and addresses are 0.
- state = FETCH.

**FETCH**
- Entry: ibus_addr = pc; ibus_en rises the cycle after entry and holds until ibus_valid is sampled high.
- On ibus_valid: instruction ← ibus_rdata, ibus_en drops, go to EX.

**EX**
- Load (0000011) and store (0100011):
  - dbus_addr = alu_result; oplen and unsigned come from func3; dbus_wdata = rs2_data.
  - A half access with addr[0] set, or a word access with addr[1:0] ≠ 0, goes to TRAP. The cause is 4 for a load and 6 for a store; no dbus_en is issued.
  - Otherwise dbus_en = 1 and the next state is MEM.
- JAL/JALR:
  - rf_wdata = pc+4.
  - Target is pc+imm for JAL and alu_result & ~1 for JALR.
  - A target with [1:0] ≠ 0 goes to TRAP with cause 0.
- Branch (1100011): target is pc+imm when alu_result[0] ≠ func3[0], otherwise pc+4. Misaligned targets trap the same way.
- Any other opcode: rf_wdata = alu_result, next_pc = pc+4.

**MEM**
- dbus_en is held until dbus_valid. Then a load sets rf_wdata ← dbus_rdata, and the state moves to WB.
- For non-memory instructions MEM passes straight to WB.

**WB**
- rf_we pulses for 1 cycle unless the instruction is a store or a branch.
- pc ← next_pc, instret += 1, then FETCH.

**TRAP**
- trap pulses for 1 cycle; trap_cause and trap_pc = pc are latched.
- pc ← TRAP_VEC, then FETCH.
- No rf_we, no instret increment.

**Watchdog**
- A counter clears on every new request.
- It increments while ibus_en or dbus_en is high and valid is low.
- Reaching TIMEOUT_CYCLES drops the request and goes to TRAP with cause 1 (fetch), 5 (load) or 7 (store).

## Timing
- Valid inputs are sampled only while the matching enable is high. Valid asserted with enable low is ignored.
- Simultaneous valid and timeout in the same cycle: valid wins.
- Minimum instruction latency with a 1-cycle-latency bus:
  - ALU op: FETCH 2 + EX 1 + MEM 1 + WB 1 = 5 cycles.
  - Load/store: + bus latency.
- instret wraps modulo 2^64.
- pc arithmetic wraps modulo 2^32.
- Reset mid-transaction: enables drop on the same edge and no write occurs. Any late valid from the SDRAM controller is ignored.
- rf_we is never asserted in the same cycle as trap.

## Configuration
- CPU_SHORTCIRCUIT_EN defined: non-memory instructions go EX → WB directly, and ALU ops take 4 cycles.
- CPU_SHORTCIRCUIT_EN undefined: every instruction passes through MEM, as described above.

## Structure
- The shared package holds:
  - cpustage_t, extended with CPU_TRAP
  - opcode localparams for LOAD, STORE, JAL, JALR and BRANCH
  - the mcause constants 0, 1, 4, 5, 6 and 7
- One sub-module, bus_watchdog: a counter parametrised by TIMEOUT_CYCLES, with clear/run inputs and a timeout output.

## Test plan
- **Reset and ALU op:** reset, bus with 1-cycle latency, ADDI at RESET_PC → exactly one rf_we pulse with rf_wdata = alu_result, then pc = RESET_PC+4 and instret = 1.
- **Misaligned load:** LW with alu_result = 0x102 → dbus_en never rises, trap pulses with trap_cause = 4, trap_pc = old pc, pc = TRAP_VEC, instret unchanged.
- **Fetch timeout:** ibus_valid held low with TIMEOUT_CYCLES = 8 → trap after 8 enable cycles with trap_cause = 1, then fetch resumes at TRAP_VEC.
- **JAL:** JAL at pc 0x20 with imm 0x10 → rf_wdata = 0x24 and pc = 0x30. Repeat with imm 0x12 → trap_cause = 0.
- **Store with slow bus:** SW with dbus_valid after 5 cycles → dbus_en held for exactly 5 cycles, dbus_wdata = rs2_data, no rf_we.
- **Reset mid-MEM, then short-circuit timing:**
  - rst_n low during MEM → all outputs at reset values on the next edge.
  - With CPU_SHORTCIRCUIT_EN defined, ADDI retires in 4 cycles; without it, in 5.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - shared stage encodings, opcodes and mcause codes for cpu_sequencer
package cpu_sequencer_pkg;

    typedef logic [2:0] cpustage_t;

    localparam cpustage_t CPU_FETCH = 3'd0;
    localparam cpustage_t CPU_EX    = 3'd1;
    localparam cpustage_t CPU_MEM   = 3'd2;
    localparam cpustage_t CPU_WB    = 3'd3;
    localparam cpustage_t CPU_TRAP  = 3'd4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] CAUSE_INSTR_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_INSTR_FAULT    = 4'd1;
    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT    = 4'd7;

    // oplen: 0 = byte, 1 = half, 2 = word
    function automatic logic access_misaligned(input logic [1:0] oplen, input logic [1:0] addr);
        return ((oplen == 2'd1) && addr[0]) || ((oplen == 2'd2) && (addr != 2'b00));
    endfunction

endpackage

// File: rtl/cpu_sequencer_bus_watchdog.sv
// rtl/cpu_sequencer_bus_watchdog.sv - bus_watchdog: flags a request left unanswered for TIMEOUT_CYCLES cycles
module cpu_sequencer_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    // The cycle holding the last permitted count is the timeout cycle itself.
    assign timeout = run && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - RV32I multi-cycle control sequencer (FETCH/EX/MEM/WB/TRAP)
// CPU_SHORTCIRCUIT_EN: non-memory instructions skip MEM and go EX -> WB.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC       = 32'h0000_0100,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  func3,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    output logic        ibus_en,
    output logic [31:0] ibus_addr,
    input  logic        ibus_valid,
    input  logic [31:0] ibus_rdata,
    output logic        dbus_en,
    output logic        dbus_rw,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [1:0]  dbus_oplen,
    output logic        dbus_unsigned,
    input  logic        dbus_valid,
    input  logic [31:0] dbus_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    output logic [63:0] instret,
    output logic        trap,
    output logic [3:0]  trap_cause,
    output logic [31:0] trap_pc
);

    cpustage_t   state_q, state_d;
    logic [31:0] pc_q, pc_d, next_pc_q, next_pc_d, instr_q, instr_d;
    logic        ibus_en_q, ibus_en_d, dbus_en_q, dbus_en_d, dbus_rw_q, dbus_rw_d;
    logic [31:0] ibus_addr_q, ibus_addr_d, dbus_addr_q, dbus_addr_d;
    logic [31:0] dbus_wdata_q, dbus_wdata_d, rf_wdata_q, rf_wdata_d, trap_pc_q, trap_pc_d;
    logic [1:0]  dbus_oplen_q, dbus_oplen_d;
    logic        dbus_uns_q, dbus_uns_d, wb_we_q, wb_we_d;
    logic [63:0] instret_q, instret_d;
    logic [3:0]  trap_cause_q, trap_cause_d;
    logic        wd_clear, wd_run, wd_timeout, is_flow;
    logic [31:0] flow_target;

    assign wd_run = (ibus_en_q && !ibus_valid) || (dbus_en_q && !dbus_valid);

    cpu_sequencer_bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_bus_watchdog (
        .clk(clk), .rst_n(rst_n), .clear(wd_clear), .run(wd_run), .timeout(wd_timeout)
    );

    always_comb begin
        state_d = state_q;       pc_d = pc_q;             next_pc_d = next_pc_q;
        instr_d = instr_q;       ibus_en_d = ibus_en_q;   ibus_addr_d = ibus_addr_q;
        dbus_en_d = dbus_en_q;   dbus_rw_d = dbus_rw_q;   dbus_addr_d = dbus_addr_q;
        dbus_wdata_d = dbus_wdata_q; dbus_oplen_d = dbus_oplen_q; dbus_uns_d = dbus_uns_q;
        rf_wdata_d = rf_wdata_q; wb_we_d = wb_we_q;       instret_d = instret_q;
        trap_cause_d = trap_cause_q; trap_pc_d = trap_pc_q;
        wd_clear = 1'b0;         is_flow = 1'b0;          flow_target = pc_q + 32'd4;
        case (state_q)
            CPU_FETCH: begin
                if (!ibus_en_q) begin
                    ibus_en_d   = 1'b1;
                    ibus_addr_d = pc_q;
                    wd_clear    = 1'b1;
                end else if (ibus_valid) begin
                    instr_d   = ibus_rdata;
                    ibus_en_d = 1'b0;
                    state_d   = CPU_EX;
                end else if (wd_timeout) begin
                    ibus_en_d    = 1'b0;
                    trap_cause_d = CAUSE_INSTR_FAULT;
                    trap_pc_d    = pc_q;
                    state_d      = CPU_TRAP;
                end
            end
            CPU_EX: begin
                wb_we_d   = 1'b1;
                next_pc_d = pc_q + 32'd4;
`ifdef CPU_SHORTCIRCUIT_EN
                state_d   = CPU_WB;
`else
                state_d   = CPU_MEM;
`endif
                case (op)
                    OP_LOAD, OP_STORE: begin
                        dbus_addr_d  = alu_result;
                        dbus_rw_d    = (op == OP_STORE);
                        dbus_oplen_d = func3[1:0];
                        dbus_uns_d   = func3[2];
                        dbus_wdata_d = rs2_data;
                        wb_we_d      = (op == OP_LOAD);
                        if (access_misaligned(func3[1:0], alu_result[1:0])) begin
                            trap_cause_d = (op == OP_STORE) ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
                            trap_pc_d    = pc_q;
                            state_d      = CPU_TRAP;
                        end else begin
                            dbus_en_d = 1'b1;
                            wd_clear  = 1'b1;
                            state_d   = CPU_MEM;
                        end
                    end
                    OP_JAL: begin
                        is_flow     = 1'b1;
                        rf_wdata_d  = pc_q + 32'd4;
                        flow_target = pc_q + imm;
                    end
                    OP_JALR: begin
                        is_flow     = 1'b1;
                        rf_wdata_d  = pc_q + 32'd4;
                        flow_target = alu_result & ~32'd1;
                    end
                    OP_BRANCH: begin
                        is_flow = 1'b1;
                        wb_we_d = 1'b0;
                        if (alu_result[0] != func3[0]) begin
                            flow_target = pc_q + imm;
                        end
                    end
                    default: rf_wdata_d = alu_result;
                endcase
                if (is_flow) begin
                    if (flow_target[1:0] != 2'b00) begin
                        trap_cause_d = CAUSE_INSTR_MISALIGN;
                        trap_pc_d    = pc_q;
                        state_d      = CPU_TRAP;
                    end else begin
                        next_pc_d = flow_target;
                    end
                end
            end
            CPU_MEM: begin
                if (!dbus_en_q) begin
                    state_d = CPU_WB;
                end else if (dbus_valid) begin
                    dbus_en_d = 1'b0;
                    if (!dbus_rw_q) begin
                        rf_wdata_d = dbus_rdata;
                    end
                    state_d = CPU_WB;
                end else if (wd_timeout) begin
                    dbus_en_d    = 1'b0;
                    trap_cause_d = dbus_rw_q ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                    trap_pc_d    = pc_q;
                    state_d      = CPU_TRAP;
                end
            end
            CPU_WB: begin
                pc_d      = next_pc_q;
                instret_d = instret_q + 64'd1;
                state_d   = CPU_FETCH;
            end
            CPU_TRAP: begin
                pc_d    = TRAP_VEC;
                state_d = CPU_FETCH;
            end
            default: state_d = CPU_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CPU_FETCH;    pc_q <= RESET_PC;      next_pc_q <= '0;
            instr_q <= 32'h0000_0013; ibus_en_q <= 1'b0;    ibus_addr_q <= '0;
            dbus_en_q <= 1'b0;       dbus_rw_q <= 1'b0;     dbus_addr_q <= '0;
            dbus_wdata_q <= '0;      dbus_oplen_q <= '0;    dbus_uns_q <= 1'b0;
            rf_wdata_q <= '0;        wb_we_q <= 1'b0;       instret_q <= '0;
            trap_cause_q <= '0;      trap_pc_q <= '0;
        end else begin
            state_q <= state_d;      pc_q <= pc_d;          next_pc_q <= next_pc_d;
            instr_q <= instr_d;      ibus_en_q <= ibus_en_d; ibus_addr_q <= ibus_addr_d;
            dbus_en_q <= dbus_en_d;  dbus_rw_q <= dbus_rw_d; dbus_addr_q <= dbus_addr_d;
            dbus_wdata_q <= dbus_wdata_d; dbus_oplen_q <= dbus_oplen_d; dbus_uns_q <= dbus_uns_d;
            rf_wdata_q <= rf_wdata_d; wb_we_q <= wb_we_d;   instret_q <= instret_d;
            trap_cause_q <= trap_cause_d; trap_pc_q <= trap_pc_d;
        end
    end

    assign ibus_en       = ibus_en_q;
    assign ibus_addr     = ibus_addr_q;
    assign dbus_en       = dbus_en_q;
    assign dbus_rw       = dbus_rw_q;
    assign dbus_addr     = dbus_addr_q;
    assign dbus_wdata    = dbus_wdata_q;
    assign dbus_oplen    = dbus_oplen_q;
    assign dbus_unsigned = dbus_uns_q;
    assign instruction   = instr_q;
    assign pc            = pc_q;
    assign rf_we         = (state_q == CPU_WB) && wb_we_q;
    assign rf_wdata      = rf_wdata_q;
    assign instret       = instret_q;
    assign trap          = (state_q == CPU_TRAP);
    assign trap_cause    = trap_cause_q;
    assign trap_pc       = trap_pc_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] TVEC   = 32'h0000_0100;
`ifdef CPU_SHORTCIRCUIT_EN
    localparam int ALU_LAT = 4;
`else
    localparam int ALU_LAT = 5;
`endif
    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, BRANCH = 7'b1100011, ADDI = 7'b0010011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] func3 = '0;
    logic [31:0] imm = '0, alu_result = '0, rs2_data = '0, ibus_rdata = '0, dbus_rdata = '0;
    logic ibus_valid = 1'b0, dbus_valid = 1'b0;
    logic ibus_en, dbus_en, dbus_rw, dbus_unsigned, rf_we, trap;
    logic [31:0] ibus_addr, dbus_addr, dbus_wdata, instruction, pc, rf_wdata, trap_pc;
    logic [1:0] dbus_oplen;
    logic [63:0] instret;
    logic [3:0] trap_cause;

    always #5 clk = ~clk;

    cpu_sequencer #(.RESET_PC(RST_PC), .TRAP_VEC(TVEC), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .func3(func3), .imm(imm), .alu_result(alu_result),
        .rs2_data(rs2_data), .ibus_en(ibus_en), .ibus_addr(ibus_addr), .ibus_valid(ibus_valid),
        .ibus_rdata(ibus_rdata), .dbus_en(dbus_en), .dbus_rw(dbus_rw), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_oplen(dbus_oplen), .dbus_unsigned(dbus_unsigned),
        .dbus_valid(dbus_valid), .dbus_rdata(dbus_rdata), .instruction(instruction), .pc(pc),
        .rf_we(rf_we), .rf_wdata(rf_wdata), .instret(instret), .trap(trap),
        .trap_cause(trap_cause), .trap_pc(trap_pc)
    );

    int n_pass = 0, n_total = 0;
    int i_lat = 1, d_lat = 1, icnt = 0, dcnt = 0;
    bit d_stray = 1'b0;
    int n_we = 0, n_trap = 0;
    logic [31:0] last_wdata = '0;
    logic [31:0] m_pc = RST_PC;
    logic [63:0] m_instret = '0;
    bit exp_we, exp_trap, exp_dbus, exp_rw, exp_uns;
    logic [3:0] exp_cause;
    logic [31:0] exp_wdata, exp_tpc, exp_daddr, exp_sdata;
    logic [1:0] exp_oplen;
    int lat, ic, dc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, req);
    endtask

    // Bus responders: valid appears on the lat-th enabled cycle; lat 0 never answers.
    always @(negedge clk) begin
        #1;
        if (ibus_en) icnt++; else icnt = 0;
        if (dbus_en) dcnt++; else dcnt = 0;
        ibus_valid = ibus_en && (i_lat != 0) && (icnt >= i_lat);
        dbus_valid = d_stray || (dbus_en && (d_lat != 0) && (dcnt >= d_lat));
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rf_we) begin
                n_we++;
                last_wdata = rf_wdata;
                chk("rf_we_allowed", {63'd0, exp_we}, 64'd1);
                chk("rf_wdata", rf_wdata, exp_wdata);
                chk("rf_we_with_trap", {63'd0, trap}, 64'd0);
            end
            if (trap) begin
                n_trap++;
                chk("trap_allowed", {63'd0, exp_trap}, 64'd1);
                chk("trap_cause", trap_cause, exp_cause);
                chk("trap_pc", trap_pc, exp_tpc);
            end
            if (dbus_en) begin
                chk("dbus_allowed", {63'd0, exp_dbus}, 64'd1);
                chk("dbus_addr", dbus_addr, exp_daddr);
                chk("dbus_rw", dbus_rw, exp_rw);
                chk("dbus_oplen", dbus_oplen, exp_oplen);
                chk("dbus_unsigned", dbus_unsigned, exp_uns);
                if (exp_rw) chk("dbus_wdata", dbus_wdata, exp_sdata);
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_pc"}, pc, RST_PC);
        chk({tag, "_instruction"}, instruction, 32'h0000_0013);
        chk({tag, "_trap_cause"}, trap_cause, 0);
        chk({tag, "_trap_pc"}, trap_pc, 0);
        chk({tag, "_instret"}, instret, 0);
        chk({tag, "_strobes"}, {ibus_en, dbus_en, rf_we, trap}, 0);
        chk({tag, "_addrs"}, {ibus_addr, dbus_addr}, 0);
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (!ibus_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ibus_en) chk("fetch_start_timeout", 0, 1);
    endtask

    // Called at the first cycle a fetch is enabled; returns at the next fetch's first enabled cycle.
    task automatic exec(input logic [6:0] o, input logic [2:0] f3, input logic [31:0] im,
                        input logic [31:0] alu, input logic [31:0] r2, input logic [31:0] ld,
                        input int il, input int dl);
        bit wr, tr, mis, prev, done;
        logic [3:0] cs;
        logic [31:0] wd, npc, tgt, word;
        int we0, tr0, n;
        chk("fetch_addr", ibus_addr, m_pc);
        chk("pc_at_fetch", pc, m_pc);
        chk("instret_at_fetch", instret, m_instret);
        word = {alu[15:0], im[8:0], o};
        op = o; func3 = f3; imm = im; alu_result = alu; rs2_data = r2; dbus_rdata = ld;
        ibus_rdata = word; i_lat = il; d_lat = dl; d_stray = 1'b0;
        wr = 0; tr = 0; cs = 0; wd = 0; npc = m_pc + 32'd4; exp_dbus = 0;
        if (il == 0) begin
            tr = 1; cs = 4'd1;
        end else if (o == LOAD || o == STORE) begin
            exp_daddr = alu; exp_rw = (o == STORE); exp_oplen = f3[1:0]; exp_uns = f3[2]; exp_sdata = r2;
            mis = (f3[1:0] == 2'd1 && alu[0]) || (f3[1:0] == 2'd2 && alu[1:0] != 2'b00);
            if (mis) begin
                tr = 1; cs = (o == STORE) ? 4'd6 : 4'd4;
            end else begin
                exp_dbus = 1;
                if (dl == 0) begin
                    tr = 1; cs = (o == STORE) ? 4'd7 : 4'd5;
                end else if (o == LOAD) begin
                    wr = 1; wd = ld;
                end
            end
        end else if (o == JAL || o == JALR || o == BRANCH) begin
            if (o == JAL) tgt = m_pc + im;
            else if (o == JALR) tgt = alu & 32'hFFFF_FFFE;
            else tgt = (alu[0] != f3[0]) ? m_pc + im : m_pc + 32'd4;
            if (tgt[1:0] != 2'b00) begin
                tr = 1; cs = 4'd0;
            end else begin
                npc = tgt;
                if (o != BRANCH) begin
                    wr = 1; wd = m_pc + 32'd4;
                end
            end
        end else begin
            wr = 1; wd = alu;
        end
        exp_we = wr; exp_trap = tr; exp_cause = cs; exp_wdata = wd; exp_tpc = m_pc;
        we0 = n_we; tr0 = n_trap;
        lat = 0; ic = 1; dc = 0; prev = 1'b1; done = 1'b0; n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            if (ibus_en && !prev) done = 1'b1;
            else begin
                if (ibus_en) ic++;
                if (dbus_en) dc++;
            end
            prev = ibus_en;
        end
        lat = n;
        if (!done) chk("instr_completion_timeout", 0, 1);
        chk("rf_we_count", n_we - we0, {63'd0, wr});
        chk("trap_count", n_trap - tr0, {63'd0, tr});
        if (il != 0) chk("instruction_reg", instruction, word);
        if (tr) m_pc = TVEC;
        else begin
            m_pc = npc;
            m_instret = m_instret + 64'd1;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        wait_fetch();

        exec(ADDI, 3'd0, 32'd5, 32'h55, 0, 0, 1, 1);
        chk("addi_latency", lat, ALU_LAT);
        chk("addi_wdata_lit", last_wdata, 32'h55);
        chk("addi_pc_lit", pc, 32'h4);
        chk("addi_instret_lit", instret, 1);

        exec(JAL, 3'd0, 32'h1C, 0, 0, 0, 1, 1);
        exec(JAL, 3'd0, 32'h10, 0, 0, 0, 1, 1);
        chk("jal_wdata_lit", last_wdata, 32'h24);
        chk("jal_pc_lit", pc, 32'h30);
        exec(JAL, 3'd0, 32'h12, 0, 0, 0, 1, 1);
        chk("jal_mis_cause_lit", trap_cause, 0);
        chk("jal_mis_tpc_lit", trap_pc, 32'h30);
        chk("jal_mis_pc_lit", pc, 32'h100);

        exec(LOAD, 3'd2, 0, 32'h102, 0, 0, 1, 1);
        chk("lw_mis_no_dbus_lit", dc, 0);
        chk("lw_mis_cause_lit", trap_cause, 4);
        chk("lw_mis_instret_lit", instret, 3);

        exec(ADDI, 3'd0, 0, 32'h9, 0, 0, 0, 1);
        chk("fetch_to_en_cycles_lit", ic, 8);
        chk("fetch_to_cause_lit", trap_cause, 1);
        chk("fetch_to_resume_lit", ibus_addr, 32'h100);

        exec(LOAD, 3'd2, 0, 32'h200, 0, 32'hDEAD_BEEF, 1, 3);
        chk("lw_wdata_lit", last_wdata, 32'hDEAD_BEEF);
        exec(LOAD, 3'd4, 0, 32'h203, 0, 32'h7F, 1, 1);
        exec(STORE, 3'd2, 0, 32'h300, 32'hCAFE_F00D, 0, 1, 5);
        chk("sw_dbus_cycles_lit", dc, 5);
        chk("sw_pc_lit", pc, 32'h10C);
        exec(STORE, 3'd1, 0, 32'h301, 32'h1234, 0, 1, 1);
        chk("sh_mis_cause_lit", trap_cause, 6);

        exec(BRANCH, 3'd0, 32'h40, 32'h1, 0, 0, 1, 1);
        chk("beq_taken_pc_lit", pc, 32'h140);
        exec(BRANCH, 3'd1, 32'h40, 32'h1, 0, 0, 1, 1);
        exec(BRANCH, 3'd1, 32'h6, 32'h0, 0, 0, 1, 1);
        exec(JALR, 3'd0, 0, 32'h1001, 0, 0, 1, 1);
        chk("jalr_wdata_lit", last_wdata, 32'h104);
        chk("jalr_pc_lit", pc, 32'h1000);
        exec(LOAD, 3'd2, 0, 32'h400, 0, 0, 1, 0);
        chk("lw_to_dbus_cycles_lit", dc, 8);
        exec(STORE, 3'd2, 0, 32'h404, 32'h55AA, 0, 1, 0);
        chk("sw_to_cause_lit", trap_cause, 7);

        op = LOAD; func3 = 3'd2; alu_result = 32'h400; d_lat = 0; i_lat = 1;
        exp_dbus = 1; exp_daddr = 32'h400; exp_rw = 0; exp_oplen = 2'd2; exp_uns = 0; exp_we = 0; exp_trap = 0;
        for (int k = 0; k < 20 && !dbus_en; k++) @(negedge clk);
        chk("mid_mem_reached", {63'd0, dbus_en}, 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset("mid_mem");
        @(negedge clk);
        rst_n = 1'b1;
        d_stray = 1'b1;
        m_pc = RST_PC;
        m_instret = '0;
        wait_fetch();
        exec(ADDI, 3'd0, 0, 32'h77, 0, 0, 1, 1);
        chk("post_rst_wdata_lit", last_wdata, 32'h77);
        chk("post_rst_instret_lit", instret, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
